// File: rtl/uart_tx_sched.sv
// Two-requester UART transmit scheduler: round-robin grant, serializer sequencing
// and start/data/parity/stop framing at one bit per CLK cycle.
module uart_tx_sched #(
  parameter int   DATA_W    = 8,
  parameter logic PRIO_INIT = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  input  logic [DATA_W-1:0] REQ0_DATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [DATA_W-1:0] REQ1_DATA,
  output logic              REQ1_READY,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] SER_P_DATA,
  output logic              SER_DATA_VALID,
  output logic              SER_EN,
  input  logic              SER_DATA,
  output logic              TX_OUT,
  output logic              BUSY,
  output logic              GRANT_ID
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] data_reg;
  logic              par_en_r;
  logic              par_typ_r;
  logic              last_grant;
  logic              grant_id_r;

  logic              any_valid_s;
  logic              arb_phase_s;
  logic              grant_s;
  logic              win1_s;

  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign any_valid_s = REQ0_VALID | REQ1_VALID;
  assign arb_phase_s = (state_r == IDLE) || (state_r == STOP);
  assign grant_s     = arb_phase_s & any_valid_s & RST;
  // On a tie the requester that did not win last time takes the frame.
  assign win1_s      = (REQ0_VALID & REQ1_VALID) ? ~last_grant : REQ1_VALID;
  assign REQ0_READY  = grant_s & ~win1_s;
  assign REQ1_READY  = grant_s & win1_s;
  assign SER_P_DATA  = data_reg;
  assign GRANT_ID    = grant_id_r;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Bit counter and grant capture of byte, parity config and owner.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt    <= {CNT_W{1'b0}};
      data_reg   <= {DATA_W{1'b0}};
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      last_grant <= PRIO_INIT;
      grant_id_r <= 1'b0;
    end else begin
      if (state_r == START) begin
        bit_cnt <= {CNT_W{1'b0}};
      end else if ((state_r == DATA) && (bit_cnt != LAST_BIT)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        bit_cnt <= bit_cnt;
      end
      if (grant_s) begin
        data_reg   <= win1_s ? REQ1_DATA : REQ0_DATA;
        par_en_r   <= PAR_EN;
        par_typ_r  <= PAR_TYP;
        last_grant <= win1_s;
        grant_id_r <= win1_s;
      end else begin
        data_reg   <= data_reg;
        par_en_r   <= par_en_r;
        par_typ_r  <= par_typ_r;
        last_grant <= last_grant;
        grant_id_r <= grant_id_r;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_valid_s) next_state_s = LOAD;
        else             next_state_s = IDLE;
      end
      LOAD:  next_state_s = START;
      START: next_state_s = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) next_state_s = par_en_r ? PARITY : STOP;
        else                     next_state_s = DATA;
      end
      PARITY: next_state_s = STOP;
      STOP: begin
        if (any_valid_s) next_state_s = LOAD;
        else             next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Line and serializer control decode.
  always_comb begin
    TX_OUT         = 1'b1;
    BUSY           = 1'b1;
    SER_EN         = 1'b0;
    SER_DATA_VALID = 1'b0;
    case (state_r)
      IDLE:   BUSY = 1'b0;
      LOAD:   SER_DATA_VALID = 1'b1;
      START: begin
        TX_OUT = 1'b0;
        SER_EN = 1'b1;
      end
      DATA: begin
        TX_OUT = SER_DATA;
        SER_EN = (bit_cnt != LAST_BIT);
      end
      PARITY: TX_OUT = parity_bit(data_reg, par_typ_r);
      STOP:   TX_OUT = 1'b1;
      default: begin
        TX_OUT = 1'b1;
        BUSY   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural serializer and a
// frame/arbitration reference model.
module tb_uart_tx_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [7:0] REQ0_DATA = 8'h00, REQ1_DATA = 8'h00;
  logic       REQ0_READY, REQ1_READY;
  logic       PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [7:0] SER_P_DATA;
  logic       SER_DATA_VALID, SER_EN;
  logic       SER_DATA;
  logic       TX_OUT, BUSY, GRANT_ID;

  int   checks = 0;
  int   errors = 0;
  logic model_last = 1'b1;
  logic [7:0] ser_sh;

  uart_tx_sched #(.DATA_W(8), .PRIO_INIT(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .SER_P_DATA(SER_P_DATA), .SER_DATA_VALID(SER_DATA_VALID), .SER_EN(SER_EN),
    .SER_DATA(SER_DATA), .TX_OUT(TX_OUT), .BUSY(BUSY), .GRANT_ID(GRANT_ID)
  );

  always #5 CLK = ~CLK;

  // Serializer: load on strobe, shift LSB first onto a registered output.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ser_sh   <= 8'h00;
      SER_DATA <= 1'b0;
    end else if (SER_DATA_VALID) begin
      ser_sh <= SER_P_DATA;
    end else if (SER_EN) begin
      SER_DATA <= ser_sh[0];
      ser_sh   <= {1'b0, ser_sh[7:1]};
    end
  end

  // Expected line bits from the LOAD cycle through STOP.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic pe, input logic pt);
    logic [11:0] b;
    int ones;
    ones = $countones(d);
    b = 12'hFFF;
    b[1] = 1'b0;
    for (int i = 0; i < 8; i++) b[2+i] = d[i];
    if (pe) b[10] = ((ones % 2) == 1) ? ~pt : pt;
    return b;
  endfunction

  task automatic wait_grant(input string name, output logic id, output int waited);
    logic exp_id;
    id = 1'b0;
    waited = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (REQ0_READY || REQ1_READY) begin
        exp_id = (REQ0_VALID && REQ1_VALID) ? ~model_last : REQ1_VALID;
        id = REQ1_READY;
        waited = i;
        checks++;
        if ((REQ0_READY && REQ1_READY) || id !== exp_id) begin
          errors++;
          $display("FAIL %s grant: ready0=%b ready1=%b required winner %0d", name, REQ0_READY, REQ1_READY, exp_id);
        end
        model_last = exp_id;
        break;
      end
      @(negedge CLK);
    end
    if (waited < 0) begin
      checks++;
      errors++;
      $display("FAIL %s grant timeout: no READY within 20 cycles", name);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic pe, input logic pt,
                             input logic exp_id, input logic drop, input logic toggle, input logic pulse);
    logic [11:0] bits;
    int n, sen;
    bits = frame_bits(d, pe, pt);
    n = pe ? 12 : 11;
    sen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      if (k == 0 && drop) begin REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; end
      if (k == 3 && toggle) begin PAR_TYP = ~PAR_TYP; PAR_EN = $urandom_range(0, 1); end
      if (k == 4 && pulse) begin REQ0_VALID = 1'b1; REQ0_DATA = 8'h3C; end
      if (k == 7 && pulse) REQ0_VALID = 1'b0;
      #1;
      checks++;
      if (TX_OUT !== bits[k] || BUSY !== 1'b1 || GRANT_ID !== exp_id) begin
        errors++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b gid=%b required tx=%b busy=1 gid=%b", name, k, TX_OUT, BUSY, GRANT_ID, bits[k], exp_id);
      end
      if (k < n - 1) begin
        checks++;
        if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin
          errors++;
          $display("FAIL %s ready in frame cycle %0d: %b%b required 00", name, k, REQ0_READY, REQ1_READY);
        end
      end
      if (k == 0) begin
        checks++;
        if (SER_DATA_VALID !== 1'b1 || SER_P_DATA !== d) begin
          errors++;
          $display("FAIL %s load: valid=%b pdata=%h required 1 %h", name, SER_DATA_VALID, SER_P_DATA, d);
        end
      end
      if (SER_EN === 1'b1) sen++;
    end
    checks++;
    if (sen != 8) begin
      errors++;
      $display("FAIL %s ser_en count: %0d required 8", name, sen);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b0 || TX_OUT !== 1'b1 || SER_EN !== 1'b0 || SER_DATA_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b tx=%b en=%b ldv=%b required 0 1 0 0", name, BUSY, TX_OUT, SER_EN, SER_DATA_VALID);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || SER_EN !== 1'b0 || SER_DATA_VALID !== 1'b0 ||
        REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0 || GRANT_ID !== 1'b0 || SER_P_DATA !== 8'h00) begin
      errors++;
      $display("FAIL reset: tx=%b busy=%b en=%b ldv=%b rdy=%b%b gid=%b pd=%h required 1 0 0 0 00 0 00",
               TX_OUT, BUSY, SER_EN, SER_DATA_VALID, REQ0_READY, REQ1_READY, GRANT_ID, SER_P_DATA);
    end
    @(negedge CLK);
    RST = 1'b1;
    model_last = 1'b1;
    check_idle("reset_release");
  endtask

  task automatic test_single();
    logic id; int w;
    @(negedge CLK);
    REQ0_DATA = 8'hA5; REQ0_VALID = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    wait_grant("single", id, w);
    check_frame("single", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_idle("single_end");
  endtask

  task automatic test_parity();
    logic id; int w;
    for (int t = 0; t < 2; t++) begin
      @(negedge CLK);
      REQ1_DATA = 8'hA5; REQ1_VALID = 1'b1; PAR_EN = 1'b1; PAR_TYP = t[0];
      wait_grant("parity", id, w);
      check_frame("parity", 8'hA5, 1'b1, t[0], 1'b1, 1'b1, 1'b0, 1'b0);
      check_idle("parity_end");
    end
  endtask

  task automatic test_back_to_back();
    logic id; int w;
    @(negedge CLK);
    REQ0_DATA = 8'h11; REQ1_DATA = 8'h22; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_grant("b2b", id, w);
      checks++;
      if (id !== f[0] || w != 0) begin
        errors++;
        $display("FAIL b2b frame %0d: winner=%b wait=%0d required %b 0", f, id, w, f[0]);
      end
      check_frame("b2b", f[0] ? 8'h22 : 8'h11, 1'b0, 1'b0, f[0], (f == 3), 1'b0, 1'b0);
    end
    check_idle("b2b_end");
  endtask

  task automatic test_par_toggle();
    logic id; int w;
    @(negedge CLK);
    REQ0_DATA = 8'hFF; REQ0_VALID = 1'b1; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    wait_grant("partog", id, w);
    check_frame("partog", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_idle("partog_end");
  endtask

  task automatic test_reset_mid();
    logic id; int w;
    @(negedge CLK);
    REQ0_DATA = 8'($urandom); REQ0_VALID = 1'b1; PAR_EN = 1'b0;
    wait_grant("rstmid", id, w);
    @(negedge CLK);
    REQ0_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || SER_EN !== 1'b0) begin
      errors++;
      $display("FAIL rstmid abort: tx=%b busy=%b en=%b required 1 0 0", TX_OUT, BUSY, SER_EN);
    end
    model_last = 1'b1;
    REQ1_DATA = 8'h5A; REQ1_VALID = 1'b1; PAR_EN = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    wait_grant("rstmid_after", id, w);
    checks++;
    if (id !== 1'b1) begin
      errors++;
      $display("FAIL rstmid winner: %b required 1", id);
    end
    check_frame("rstmid_after", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_idle("rstmid_end");
  endtask

  task automatic test_withdraw();
    logic id; int w;
    @(negedge CLK);
    REQ1_DATA = 8'h96; REQ1_VALID = 1'b1; PAR_EN = 1'b0;
    wait_grant("withdraw", id, w);
    check_frame("withdraw", 8'h96, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_idle("withdraw_end");
    checks++;
    if (SER_P_DATA !== 8'h96 || GRANT_ID !== 1'b1) begin
      errors++;
      $display("FAIL withdraw capture: pdata=%h gid=%b required 96 1", SER_P_DATA, GRANT_ID);
    end
  endtask

  task automatic test_random();
    logic id; int w;
    logic pe, pt;
    for (int r = 0; r < 12; r++) begin
      @(negedge CLK);
      REQ0_DATA = 8'($urandom); REQ1_DATA = 8'($urandom);
      REQ0_VALID = $urandom_range(0, 1); REQ1_VALID = $urandom_range(0, 1);
      if (!REQ0_VALID && !REQ1_VALID) REQ0_VALID = 1'b1;
      pe = $urandom_range(0, 1); pt = $urandom_range(0, 1);
      PAR_EN = pe; PAR_TYP = pt;
      wait_grant("random", id, w);
      check_frame("random", id ? REQ1_DATA : REQ0_DATA, pe, pt, id, 1'b1, 1'b1, 1'b0);
      check_idle("random_end");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_par_toggle();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
